// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the fetch controller's control inputs and
// fetch outputs.
//   master : the surrounding pipeline (hazard unit, branch unit, CP0, IM).
//            It drives stall/br_*/exc_req/eret_req/epc/im_ex.
//   slave  : fetch_ctrl. It drives pc/pc_plus4/if_valid/if_exc/if_flush/
//            fault_pending.
interface fetch_ctrl_if;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [4:0]  im_ex;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic [4:0]  if_exc;
    logic        if_flush;
    logic        fault_pending;

    modport master (
        output stall, br_valid, br_target, exc_req, eret_req, epc, im_ex,
        input  pc, pc_plus4, if_valid, if_exc, if_flush, fault_pending
    );

    modport slave (
        input  stall, br_valid, br_target, exc_req, eret_req, epc, im_ex,
        output pc, pc_plus4, if_valid, if_exc, if_flush, fault_pending
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC and sequences instruction fetch.
//   clk, reset : clock and synchronous active-high reset.
//   bus        : fetch_ctrl_if.slave
//     in : stall, br_valid/br_target, exc_req, eret_req/epc, im_ex
//     out: pc (IM address, straight from the register), pc_plus4,
//          if_valid, if_exc, if_flush, fault_pending
// In RUN the PC advances, redirects or holds by priority
// exc > eret > stall > fetch fault > branch > sequential.
// A fetch fault freezes fetching in FAULT until CP0 takes the
// exception (or an older eret commits).
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.slave   bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        bus.pc            = pc_q;
        bus.pc_plus4      = pc_q + 32'd4;
        bus.if_valid      = (state_q == RUN);
        bus.if_exc        = '0;
        bus.if_flush      = bus.exc_req | bus.eret_req;
        bus.fault_pending = (state_q == FAULT);

        if (state_q == RUN && bus.im_ex != '0)
            bus.if_exc = EXC_ADEL;

        unique case (state_q)
            RUN: begin
                if (bus.exc_req) begin
                    pc_d = HANDLER_PC;
                end else if (bus.eret_req) begin
                    pc_d = bus.epc;
                end else if (bus.stall) begin
                    // branch is re-presented once the stall clears
                    pc_d = pc_q;
                end else if (bus.im_ex != '0) begin
                    // faulting entry goes to IF/ID this cycle, then freeze
                    state_d = FAULT;
                end else if (bus.br_valid) begin
                    pc_d = bus.br_target;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FAULT: begin
                if (bus.exc_req) begin
                    pc_d    = HANDLER_PC;
                    state_d = RUN;
                end else if (bus.eret_req) begin
                    pc_d    = bus.epc;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                pc_d    = RESET_PC;
            end
        endcase
    end

endmodule
